// File: rtl/vld_pkg.sv
// Shared constants and FSM encoding for the vector-load gather unit.
package vld_pkg;
  localparam int DW          = 32;
  localparam int AW          = 32;
  localparam int LANES       = 8;
  localparam int VRW         = 2;
  localparam int LANE_IW     = $clog2(LANES);
  localparam int BYTE_STRIDE = 4;
  localparam logic [VRW-1:0] VD_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    COMMIT
  } state_t;
endpackage

// File: rtl/vld_lane_buffer.sv
// LANES x DW element buffer: synchronous clear, single-lane write, flat readout.
module vld_lane_buffer
  import vld_pkg::*;
#(
  parameter int W = DW,
  parameter int N = LANES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_idx,
  input  logic [W-1:0]         wr_data,
  output logic [N*W-1:0]       vwdata
);
  logic [W-1:0] lane [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) lane[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < N; i++) lane[i] <= '0;
    end else if (wr_en) begin
      lane[wr_idx] <= wr_data;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign vwdata[g*W +: W] = lane[g];
  end
endmodule

// File: rtl/vld_gather_unit.sv
// Vector-load gather unit: fetches up to LANES words one request at a time and
// commits them to a vector register with a single whole-vector write pulse.
module vld_gather_unit
  import vld_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [VRW-1:0]       vd,
  input  logic [31:0]          vlen,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 mem_req,
  output logic [AW-1:0]        mem_addr,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 vreg_write,
  output logic [VRW-1:0]       vreg_addr,
  output logic [LANES*DW-1:0]  vwdata
);
  localparam int NW = LANE_IW + 1;

  state_t             state, state_nxt;
  logic [AW-1:0]      base_q;
  logic [VRW-1:0]     vd_q;
  logic [NW-1:0]      n_q;
  logic [LANE_IW-1:0] idx_q;
  logic               error_q;

  logic               illegal, accept, last, clear, wr_en;
  logic [NW-1:0]      n_clamp;

  assign illegal = (vd == VD_ILLEGAL) || (base_addr[1:0] != 2'b00);
  assign accept  = start && (state == IDLE) && !illegal;
  // Full-width compare so large vlen values clamp instead of aliasing.
  assign n_clamp = (vlen > 32'(LANES)) ? NW'(LANES) : vlen[NW-1:0];
  assign last    = ({1'b0, idx_q} == (n_q - 1'b1));

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          clear     = 1'b1;
          state_nxt = (n_clamp == '0) ? COMMIT : REQ;
        end
      end
      REQ:    if (mem_gnt) state_nxt = WAIT;
      WAIT: begin
        if (mem_rvalid) begin
          wr_en     = 1'b1;
          state_nxt = last ? COMMIT : REQ;
        end
      end
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      base_q  <= '0;
      vd_q    <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      error_q <= start && (state == IDLE) && illegal;
      if (accept) begin
        base_q <= base_addr;
        vd_q   <= vd;
        n_q    <= n_clamp;
        idx_q  <= '0;
      end else if ((state == WAIT) && mem_rvalid && !last) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign mem_req    = (state == REQ);
  assign mem_addr   = mem_req ? (base_q + (AW'(idx_q) * AW'(BYTE_STRIDE))) : '0;
  assign vreg_write = (state == COMMIT);
  assign done       = vreg_write;
  assign vreg_addr  = vreg_write ? vd_q : '0;
  assign error      = error_q;

  vld_lane_buffer #(.W(DW), .N(LANES)) u_lanes (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_data (mem_rdata),
    .vwdata  (vwdata)
  );
endmodule

// File: tb/tb_vld_gather_unit.sv
// Scoreboard bench for vld_gather_unit: randomized loads, reference memory
// model, decoupled commit/error monitor and address checker.
module tb_vld_gather_unit;
  import vld_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [AW-1:0]       base_addr;
  logic [VRW-1:0]      vd;
  logic [31:0]         vlen;
  logic                busy, done, error, mem_req, vreg_write;
  logic [AW-1:0]       mem_addr;
  logic                mem_gnt, mem_rvalid;
  logic [DW-1:0]       mem_rdata;
  logic [VRW-1:0]      vreg_addr;
  logic [LANES*DW-1:0] vwdata;

  vld_gather_unit dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .vd(vd),
    .vlen(vlen), .busy(busy), .done(done), .error(error), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .vreg_write(vreg_write), .vreg_addr(vreg_addr),
    .vwdata(vwdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                  is_err;
    logic [VRW-1:0]      addr;
    logic [LANES*DW-1:0] data;
    int                  cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] salt = 32'h0;
  int          gnt_dly = 0;
  int          rv_dly = 0;
  bit          rand_dly = 1'b0;
  bit          junk_rv = 1'b0;
  bit          mem_busy = 1'b0;
  int          gnt_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LANES*DW-1:0] act,
                     input logic [LANES*DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a ^ salt) + 32'd1;
  endfunction

  // Reference model: expectation is derived from request fields only.
  task automatic issue_load(input logic [31:0] b, input logic [1:0] v,
                            input logic [31:0] len, input bit timed);
    exp_t        e;
    int          n;
    logic [31:0] a;
    @(negedge clk);
    start = 1'b1; base_addr = b; vd = v; vlen = len;
    e.is_err = 1'b0; e.addr = '0; e.data = '0; e.cyc = -1;
    if (v == 2'd3 || b[1:0] != 2'b00) begin
      e.is_err = 1'b1;
      e.cyc    = cyc + 1;
    end else begin
      n = (len > 32'd8) ? 8 : int'(len);
      for (int i = 0; i < n; i++) begin
        a = b + 32'(4 * i);
        e.data[i*DW +: DW] = mem_fn(a);
        addr_q.push_back(a);
      end
      e.addr = v;
      if (timed) e.cyc = cyc + 2 * n + 1;
    end
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(exp_q.size() == 0 && busy == 1'b0 && !mem_busy) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: %0d expectations still pending", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    chk("addr_q_drained", addr_q.size(), 0);
    addr_q.delete();
  endtask

  // Monitor: pops an expectation whenever the DUT commits or flags an error.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0) begin
      if (vreg_write === 1'b1 || done === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].is_err) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: vreg_write=%0b done=%0b", vreg_write, done);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          e = exp_q.pop_front();
          chk("vreg_addr", vreg_addr, e.addr);
          chk("vwdata", vwdata, e.data);
          chk("done_with_write", {done, vreg_write}, 2'b11);
          if (e.cyc >= 0) chk("commit_cycle", cyc, e.cyc);
        end
      end
      if (error === 1'b1) begin
        if (exp_q.size() == 0 || !exp_q[0].is_err) begin
          checks++;
          errors++;
          $display("FAIL unexpected_error: error=%0b", error);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          e = exp_q.pop_front();
          chk("error_cycle", cyc, e.cyc);
          chk("error_idle", {busy, mem_req, vreg_write}, 3'b000);
        end
      end
    end
  end

  // Memory responder: one outstanding read, configurable grant/data delays.
  initial begin : responder
    logic [31:0] a;
    int          gd, rd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    forever begin
      if (mem_req === 1'b1) begin
        mem_busy = 1'b1;
        a  = mem_addr;
        gd = rand_dly ? $urandom_range(0, 3) : gnt_dly;
        rd = rand_dly ? $urandom_range(0, 3) : rv_dly;
        for (int k = 0; k < gd; k++) begin
          @(negedge clk);
          chk("mem_addr_stable", {mem_req, mem_addr}, {1'b1, a});
        end
        mem_gnt = 1'b1;
        if (junk_rv) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hdead_beef;
        end
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: addr %0h", a);
        end else begin
          chk("mem_addr", a, addr_q.pop_front());
        end
        gnt_count++;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        for (int k = 0; k < rd; k++) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = mem_fn(a);
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_busy   = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] b, len;
    logic [1:0]  v;
    int          g0, t;
    rst = 1'b1; start = 1'b0; base_addr = '0; vd = '0; vlen = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, done, error, mem_req, vreg_write}, 5'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_vreg_addr", vreg_addr, 0);
    chk("rst_vwdata", vwdata, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    issue_load(32'h100, 2'd1, 32'd8, 1'b1); wait_idle();
    salt = 32'h5a5a_0000;
    issue_load(32'h40, 2'd0, 32'd3, 1'b1);  wait_idle();
    issue_load(32'h80, 2'd2, 32'h20, 1'b1); wait_idle();
    issue_load(32'h200, 2'd1, 32'd0, 1'b1); wait_idle();
    issue_load(32'h300, 2'd3, 32'd4, 1'b1); wait_idle();
    issue_load(32'h102, 2'd1, 32'd4, 1'b1); wait_idle();

    // Slow memory plus ignored start pulses while busy.
    gnt_dly = 3; rv_dly = 2; salt = 32'h1234_5678;
    issue_load(32'h500, 2'd2, 32'd6, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1; base_addr = 32'h703; vd = 2'd3; vlen = 32'd2;
    @(negedge clk);
    start = 1'b1; base_addr = 32'h900; vd = 2'd0; vlen = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset while waiting on the fifth element's data.
    gnt_dly = 0; rv_dly = 6;
    g0 = gnt_count;
    issue_load(32'h600, 2'd2, 32'd8, 1'b0);
    t = 0;
    while (gnt_count < g0 + 5 && t < 500) begin @(negedge clk); t++; end
    chk("reset_reach_wait", (gnt_count >= g0 + 5), 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", {busy, done, error, mem_req, vreg_write}, 5'b0);
    chk("midrst_vwdata", vwdata, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    rv_dly = 0;
    issue_load(32'h1000, 2'd0, 32'd5, 1'b1); wait_idle();

    issue_load(32'hFFFF_FFF8, 2'd1, 32'd4, 1'b1); wait_idle();

    for (int it = 0; it < 30; it++) begin
      salt = $urandom;
      b = $urandom;
      b[1:0] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0: len = $urandom_range(0, 8);
        1: len = $urandom_range(9, 40);
        2: len = $urandom;
        default: len = $urandom_range(0, 2);
      endcase
      rand_dly = 1'($urandom_range(0, 1));
      junk_rv  = 1'($urandom_range(0, 1));
      issue_load(b, v, len, !rand_dly);
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vld_gather_unit.md
Name: vld_gather_unit

Overview:
- Vector-load gather unit: the writer side of the vector register file's VRegWrite path.
- Fetches up to 8 consecutive 32-bit words from data memory and assembles them into a lane buffer.
- Commits them to vector register v0/v1/v2 with a single-cycle whole-vector write pulse.
- Sits between the decode/control stage (start, base address, vd, vlen from gpr[7]) and the data-memory port.

Parameters:
DW, 32, data/lane width
AW, 32, memory address width
LANES, 8, elements per vector register
VRW, 2, vector register index width

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a vector load
base_addr  in  AW  byte address of element 0
vd  in  VRW  destination vector register (0..2 legal)
vlen  in  32  requested element count (gpr[7])
busy  out  1  high while a load is in progress
done  out  1  one-cycle pulse on successful commit
error  out  1  one-cycle pulse on rejected request
mem_req  out  1  memory read request
mem_addr  out  AW  memory read address
mem_gnt  in  1  memory accepts the request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  DW  read data
vreg_write  out  1  one-cycle whole-vector write strobe
vreg_addr  out  VRW  vector register index for vreg_write
vwdata  out  LANES*DW  lane i at bits [i*DW +: DW]

Behaviour:
- Reset (async, rst=1): state IDLE. busy, done, error, mem_req, vreg_write all 0. mem_addr 0, vreg_addr 0, vwdata 0. Reset mid-operation aborts the load; a late mem_rvalid is ignored.
- FSM states: IDLE, REQ, WAIT, COMMIT.
- IDLE, start=1:
  - If vd==3 or base_addr[1:0]!=0: pulse error next cycle, stay IDLE, issue no memory access.
  - Otherwise latch base_addr and vd, set n=min(vlen,8) using a full 32-bit compare, clear all lanes to 0, set idx=0.
  - If n==0, go to COMMIT; else go to REQ.
- REQ: mem_req=1, mem_addr=base+(idx<<2) modulo 2^AW. Address and request are held stable until mem_gnt=1, then go to WAIT.
- WAIT: mem_req=0. On mem_rvalid, lane[idx]<=mem_rdata. If idx==n-1 go to COMMIT, else increment idx and go to REQ.
- COMMIT: for exactly one cycle, vreg_write=1, vreg_addr=vd, done=1. Then go to IDLE.
- Lanes idx>=n remain 0 (zero-fill tail).
- vwdata is registered and holds its value until the next accepted start clears it.
- busy=1 in REQ/WAIT/COMMIT. start while busy is ignored, with no error.
- Only one outstanding request is allowed. mem_rvalid outside WAIT is ignored.
- mem_gnt and mem_rvalid in the same cycle as REQ: only gnt is honoured, and rvalid is expected from the next cycle onward.
- Latency with zero-wait memory (gnt in REQ cycle, rvalid the following cycle): vreg_write asserts 2n+1 cycles after the start cycle. For n=0, it asserts 1 cycle after.

Decomposition:
- Shared package vld_pkg: state enum (IDLE, REQ, WAIT, COMMIT), LANES, DW, VRW, the VD_ILLEGAL=3 constant, and the byte-stride constant 4.
- Sub-module vld_lane_buffer: LANES x DW register array with synchronous clear, indexed single-lane write, and flat vwdata output.
- FSM, address generation and clamp stay in vld_gather_unit.

Test Plan:
- vd=1, base=0x100, vlen=8, memory returns addr+1, zero-wait -> 8 requests at 0x100..0x11C. vreg_write at cycle 17 with vreg_addr=1. Lane i = 0x101+4i. done pulses once.
- vlen=3, vd=0, base=0x40 -> 3 requests. Lanes 0..2 = data, lanes 3..7 = 0. vlen=0x20 -> clamped to 8 requests. vlen=0 -> no mem_req, vreg_write 1 cycle after start, vwdata all 0.
- vd=3 or base=0x102 -> error pulse 1 cycle, mem_req never asserts, busy stays 0, no vreg_write.
- mem_gnt delayed 3 cycles and rvalid delayed 2 cycles per element -> mem_addr stable while mem_req=1. Correct lanes. start pulsed during busy is ignored.
- rst asserted in WAIT after 4 elements, then rvalid arrives -> outputs 0 immediately. No vreg_write. A subsequent load completes normally.
- base=0xFFFFFFF8, vlen=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap).
